bcd_display_controller: RTL
===========================

# bcd_display_controller

Sequential binary-to-BCD conversion and 4-digit seven-segment scan controller for Digilent boards. It accepts a 14-bit binary value over a valid/ready handshake and converts it with an iterative shift-add-3 (double-dabble) datapath. It holds the four result digits in output registers and time-multiplexes them onto a common-anode 4-digit display. It replaces the combinational converter wherever a value must be shown on the board display.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is driven (1 ms at 100 MHz); legal range 2..2^20.
- BLANK_LEADING, 1: 1 = blank leading zero digits; 0 = show all four digits.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request to convert `in`.
- in  in  14  binary value, 0..16383.
- in_ready  out  1  high only in IDLE and not in reset; a transfer occurs on an edge where in_valid & in_ready.
- done  out  1  one-cycle pulse: new digits valid.
- overflow  out  1  latched with each result; 1 if the accepted value > 9999.
- ones, tens, hundreds, thousands  out  4 each  result BCD digits, registered.
- an  out  4  anode enables, active-low, an[0] = ones.
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On transfer: capture `in` into a 14-bit shift register, clear the 16-bit BCD accumulator and iteration counter, then go to SHIFT.
  - Set the overflow-pending flag = (in > 9999).
- SHIFT, one iteration per cycle:
  - Add 3 to every accumulator nibble ≥ 5.
  - Then shift {accumulator, binary} left by 1.
  - Exactly 14 iterations, then go to DONE.
  - Values > 9999 run the full 14 iterations anyway, so latency is fixed.
- Entering DONE (same edge): load the digit registers and overflow.
  - Overflow-pending = 0: digits = accumulator nibbles.
  - Overflow-pending = 1: digits saturate to 9,9,9,9 and overflow = 1.
- DONE: done=1, in_ready=0 for one cycle, then return to IDLE.
- in_valid outside IDLE is ignored, not queued. `in` is sampled only on the transfer edge.
- Digit registers change only on the DONE-entry edge. The display never shows partial conversions.
- Scanner:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0.
  - an = one-hot-low of the index: 1110, 1101, 1011, 0111.
  - seg = encoding of the selected digit register.
- Encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Digit codes 10–15 cannot occur; drive 1111111.
- Blanking (BLANK_LEADING=1): while a blanked digit is selected, seg=1111111; the anode still follows the scan.
  - thousands is blanked if it is 0.
  - hundreds is blanked if thousands and hundreds are both 0.
  - tens is blanked if thousands, hundreds and tens are all 0.
  - ones is never blanked.

## Timing
- Reset values:
  - FSM = IDLE.
  - All digit registers = 0.
  - overflow = 0, done = 0.
  - Refresh counter = 0, digit index = 0.
  - an = 1110, seg = 1000000.
  - in_ready = 0 during the reset cycle and 1 from the first cycle after reset.
- Transfer on edge E0:
  - in_ready=0 from after E0.
  - SHIFT iterations occur on edges E1–E14.
  - DONE is entered on E15: digits and overflow are updated, and done=1 for the cycle after E15.
  - IDLE on E16, so in_ready=1 after E16; the next transfer is at E17 at the earliest.
  - Throughput: one conversion per 17 cycles.
- Reset asserted in any state:
  - Aborts the conversion; no done pulse.
  - All outputs return to their reset values on that edge.
  - The scanner restarts at index 0.
- The scanner runs independently of the FSM. A digit update on E15 appears on seg within the same cycle when that digit is selected.

## Test plan
- Reset, then transfer in=1234 at E0 → done high only in the cycle after E15; thousands=1, hundreds=2, tens=3, ones=4; overflow=0.
- in=0 with REFRESH_DIV=4 → over 16 cycles an = 1110, 1101, 1011, 0111, each held 4 cycles; seg=1000000 only while an=1110, otherwise 1111111. Repeat with BLANK_LEADING=0 → seg=1000000 on all four digits.
- in=10000, then in=16383 → digits 9,9,9,9 and overflow=1 on both; next in=9999 → digits 9,9,9,9 and overflow=0.
- in_valid held high with in=42 and then in=7 presented during SHIFT → only 42 is converted; in_ready=0 over E1–E16; the next transfer is accepted at E17.
- Reset pulsed at E7 of a conversion of 5678 → no done pulse; digits=0; in_ready=1 on the cycle after reset deasserts.
- Exhaustive sweep in=0..9999, each a back-to-back transfer → at every done, digits equal the decimal decomposition of the input and overflow=0.

Source files
------------

// File: rtl/bcd_display_controller.sv
// Binary-to-BCD converter (iterative double-dabble) feeding a 4-digit,
// common-anode seven-segment scan controller with optional leading-zero blanking.
module bcd_display_controller #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [13:0] in,
    output logic        in_ready,
    output logic        done,
    output logic        overflow,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    // Iteration counter reaches 14 after the last shift; that cycle only commits.
    localparam logic [3:0]      LAST_ITER = 4'd14;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  iter_q, iter_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] digits_q, digits_d;   // {thousands, hundreds, tens, ones}
    logic        overflow_q, overflow_d;
    logic [15:0] acc_adj;

    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       blank;
    logic [3:0]       sel_digit;

    // Add-3 correction for every accumulator nibble that is 5 or more.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                        (acc_q[gi*4 +: 4] + 4'd3) : acc_q[gi*4 +: 4];
        end
    endgenerate

    assign in_ready  = (state_q == IDLE) && !reset;
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;
    assign ones      = digits_q[3:0];
    assign tens      = digits_q[7:4];
    assign hundreds  = digits_q[11:8];
    assign thousands = digits_q[15:12];

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    bin_d      = in;
                    acc_d      = '0;
                    iter_d     = '0;
                    ovf_pend_d = (in > 14'd9999);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (iter_q == LAST_ITER) begin
                    // Commit the whole result at once so the display never sees partial digits.
                    state_d = DONE;
                    if (ovf_pend_q) begin
                        digits_d   = 16'h9999;
                        overflow_d = 1'b1;
                    end else begin
                        digits_d   = acc_q;
                        overflow_d = 1'b0;
                    end
                end else begin
                    acc_d  = {acc_adj[14:0], bin_q[13]};
                    bin_d  = {bin_q[12:0], 1'b0};
                    iter_d = iter_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Conversion state and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

    // Refresh divider and digit index advance.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == CNT_MAX) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    // Scanner registers, independent of the converter.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
        end
    end

    // Leading-zero blanking per digit position; ones is always shown.
    always_comb begin
        blank = 4'b0000;
        if (BLANK_LEADING) begin
            blank[3] = (digits_q[15:12] == 4'd0);
            blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
            blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
        end
    end

    // Anode select and segment encoding of the selected digit.
    always_comb begin
        sel_digit = digits_q[idx_q*4 +: 4];
        an        = ~(4'b0001 << idx_q);
        case (sel_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (blank[idx_q]) begin
            seg = 7'b1111111;
        end
    end

endmodule
